// File: rtl/sbox_engine.sv
// sbox_engine: iterative multi-lane AES byte substitution (SubBytes / InvSubBytes).
//
// A BYTES-wide word is accepted on an in_valid/in_ready handshake, substituted LANES bytes per
// clock over BYTES/LANES beats, then held on out_data until out_valid/out_ready completes.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid, in_ready  input handshake (in_ready high only when idle)
//   in_data, in_inv     word to substitute; 1 selects the inverse S-box
//   out_valid, out_ready output handshake
//   out_data            the work register; stable while out_valid is high
//   busy                substitution in progress
//
// Build option SBOX_ENGINE_FWD_EN: when defined, forward ROMs are included and in_inv picks the
// direction per word. When undefined, only inverse ROMs exist and every word is inverted.
module sbox_engine #(
  parameter int unsigned BYTES = 16,
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*BYTES-1:0] out_data,
  output logic               busy
);

  localparam int unsigned Beats  = BYTES / LANES;
  localparam int unsigned CntW   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned SliceW = 8 * LANES;

  if (BYTES % LANES != 0) begin : g_bad_cfg
    $error("sbox_engine: BYTES must be a multiple of LANES");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [8*BYTES-1:0]  work_q, work_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SliceW-1:0]   slice_in, slice_out;

  // Each ROM is a 16-row case on the high nibble; the low nibble picks the byte, column 0 being
  // the most significant byte of the row constant.
  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    logic [127:0] row;
    row = '0;
    unique case (a[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      4'hf: row = 128'h172b047eba77d626e169146355210c7d;
      default: row = '0;
    endcase
    return row[8*(15 - int'(a[3:0])) +: 8];
  endfunction

`ifdef SBOX_ENGINE_FWD_EN
  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [127:0] row;
    row = '0;
    unique case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: row = '0;
    endcase
    return row[8*(15 - int'(a[3:0])) +: 8];
  endfunction

  logic mode_q, mode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end
`else
  // Decrypt-only build: direction is fixed to inverse, so the mode input has no effect.
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  // Select the slice belonging to the current beat.
  always_comb begin
    slice_in = '0;
    for (int b = 0; b < int'(Beats); b++) begin
      if (cnt_q == CntW'(b)) slice_in = work_q[b*SliceW +: SliceW];
    end
  end

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    logic [7:0] byte_in, inv_b;
    assign byte_in = slice_in[8*l +: 8];
    assign inv_b   = sbox_inv(byte_in);
`ifdef SBOX_ENGINE_FWD_EN
    logic [7:0] fwd_b;
    assign fwd_b = sbox_fwd(byte_in);
    assign slice_out[8*l +: 8] = mode_q ? inv_b : fwd_b;
`else
    assign slice_out[8*l +: 8] = inv_b;
`endif
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
`ifdef SBOX_ENGINE_FWD_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = in_data;
`ifdef SBOX_ENGINE_FWD_EN
          mode_d  = in_inv;
`endif
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int b = 0; b < int'(Beats); b++) begin
          if (cnt_q == CntW'(b)) work_d[b*SliceW +: SliceW] = slice_out;
        end
        if (cnt_q == CntW'(Beats - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StBusy);
  assign out_data  = work_q;

endmodule
